// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// instruction field bit positions and the PC increment.
// Latency/backpressure: not applicable (constants only).
package instr_fetch_unit_pkg;

   // Fetch FSM encoding. Kept as plain 2-bit constants so older tools and
   // waveform filters that expect fixed codes keep working.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   // Instruction word field positions.
   localparam int RS_HI = 25;
   localparam int RS_LO = 21;
   localparam int RT_HI = 20;
   localparam int RT_LO = 16;
   localparam int RD_HI = 15;
   localparam int RD_LO = 11;
   localparam int OP_HI = 2;
   localparam int OP_LO = 0;

   // Byte distance between consecutive instruction words.
   localparam int PC_STEP = 4;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, one-word-at-a-time fetch from a 1-cycle sync RAM, IR + field decode.
// Latency: Run high in IDLE -> IR_Valid 3 cycles later; throughput 1 instr / 3 cycles.
// Backpressure: IR_Ready low in HOLD freezes IR/IR_PC/IR_Valid and stops all RAM reads.
//
// Ports:
//   clk_m, Reset            clock (rising edge) and async active-low reset
//   Run                     fetch enable, sampled in IDLE and HOLD
//   Inst_Rd_En/Addr/Data    instruction RAM read strobe, byte address, read data (next cycle)
//   IR_Valid/IR_Ready       handshake toward execute; IR and IR_PC are the payload
//   Rs/Rt/Rd/ALU_OP         fields decoded from IR
//   Br_Load/Br_Target       PC load for branches/jumps (target low 2 bits ignored)
//   Fetch_Cnt               saturating count of delivered instructions
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
   parameter int                CNT_W    = 16
) (
   input  logic              clk_m,
   input  logic              Reset,
   input  logic              Run,
   output logic              Inst_Rd_En,
   output logic [ADDR_W-1:0] Inst_Addr,
   input  logic [31:0]       Inst_Data,
   output logic              IR_Valid,
   input  logic              IR_Ready,
   output logic [31:0]       IR,
   output logic [ADDR_W-1:0] IR_PC,
   output logic [4:0]        Rs,
   output logic [4:0]        Rt,
   output logic [4:0]        Rd,
   output logic [2:0]        ALU_OP,
   input  logic              Br_Load,
   input  logic [ADDR_W-1:0] Br_Target,
   output logic [CNT_W-1:0]  Fetch_Cnt
);

   logic [1:0]        state_q,     state_d;
   logic [ADDR_W-1:0] pc_q,        pc_d;
   logic [31:0]       ir_q,        ir_d;
   logic [ADDR_W-1:0] ir_pc_q,     ir_pc_d;
   logic              ir_vld_q,    ir_vld_d;
   logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;

   // Branch targets are forced onto a word boundary.
   logic [ADDR_W-1:0] br_tgt_aligned;
   assign br_tgt_aligned = Br_Target & ~ADDR_W'(3);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      ir_pc_d     = ir_pc_q;
      ir_vld_d    = ir_vld_q;
      fetch_cnt_d = fetch_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (Br_Load) pc_d = br_tgt_aligned;
            if (Run)     state_d = ST_REQ;
         end
         ST_REQ: begin
            // A branch here restarts the fetch at the target; the word being
            // read is simply never captured.
            if (Br_Load) begin
               pc_d    = br_tgt_aligned;
               state_d = ST_REQ;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (Br_Load) begin
               // Flush: drop the returning word, leave IR side untouched.
               pc_d    = br_tgt_aligned;
               state_d = ST_REQ;
            end else begin
               ir_d     = Inst_Data;
               ir_pc_d  = pc_q;
               pc_d     = pc_q + ADDR_W'(PC_STEP);
               ir_vld_d = 1'b1;
               if (fetch_cnt_q != {CNT_W{1'b1}})
                  fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
               state_d  = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // Branches are only honoured together with the consumption of the
            // instruction that produced them.
            if (IR_Ready) begin
               ir_vld_d = 1'b0;
               if (Br_Load) pc_d = br_tgt_aligned;
               state_d  = Run ? ST_REQ : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_m or negedge Reset) begin
      if (!Reset) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         ir_q        <= '0;
         ir_pc_q     <= '0;
         ir_vld_q    <= 1'b0;
         fetch_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         ir_pc_q     <= ir_pc_d;
         ir_vld_q    <= ir_vld_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   // Read strobe is a pure state decode so it never glitches on inputs.
   assign Inst_Rd_En = (state_q == ST_REQ);
   assign Inst_Addr  = pc_q;
   assign IR_Valid   = ir_vld_q;
   assign IR         = ir_q;
   assign IR_PC      = ir_pc_q;
   assign Fetch_Cnt  = fetch_cnt_q;

   assign Rs     = ir_q[RS_HI:RS_LO];
   assign Rt     = ir_q[RT_HI:RT_LO];
   assign Rd     = ir_q[RD_HI:RD_LO];
   assign ALU_OP = ir_q[OP_HI:OP_LO];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

   logic        clk_m = 1'b0;
   logic        Reset;
   logic        Run;
   logic        Inst_Rd_En;
   logic [7:0]  Inst_Addr;
   logic [31:0] Inst_Data;
   logic        IR_Valid;
   logic        IR_Ready;
   logic [31:0] IR;
   logic [7:0]  IR_PC;
   logic [4:0]  Rs, Rt, Rd;
   logic [2:0]  ALU_OP;
   logic        Br_Load;
   logic [7:0]  Br_Target;
   logic [15:0] Fetch_Cnt;

   instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .CNT_W(16)) dut (
      .clk_m(clk_m), .Reset(Reset), .Run(Run),
      .Inst_Rd_En(Inst_Rd_En), .Inst_Addr(Inst_Addr), .Inst_Data(Inst_Data),
      .IR_Valid(IR_Valid), .IR_Ready(IR_Ready), .IR(IR), .IR_PC(IR_PC),
      .Rs(Rs), .Rt(Rt), .Rd(Rd), .ALU_OP(ALU_OP),
      .Br_Load(Br_Load), .Br_Target(Br_Target), .Fetch_Cnt(Fetch_Cnt)
   );

   always #5 clk_m = ~clk_m;

   // Instruction RAM model: word addressed by [7:2], one-cycle read latency.
   logic [31:0] mem [64];
   logic [31:0] ram_q = 32'h0;
   always @(posedge clk_m) if (Inst_Rd_En) ram_q <= mem[Inst_Addr[7:2]];
   assign Inst_Data = ram_q;

   typedef struct {
      logic [31:0] w;
      logic [7:0]  pc;
      logic [15:0] cnt;
   } exp_t;

   logic [7:0] addr_q [$];
   exp_t       ir_q   [$];

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expect one RAM read at addr that is delivered as instruction #cnt.
   task automatic push_fetch(input logic [7:0] addr, input logic [15:0] cnt);
      exp_t e;
      e.w   = mem[addr[7:2]];
      e.pc  = addr;
      e.cnt = cnt;
      addr_q.push_back(addr);
      ir_q.push_back(e);
   endtask

   // Monitor: checks every RAM read address and every consumed instruction.
   always @(negedge clk_m) begin
      if (Inst_Rd_En) begin
         if (addr_q.size() == 0) begin
            chk("unexpected_fetch_addr", {24'h0, Inst_Addr}, 32'hFFFF_FFFF);
         end else begin
            chk("fetch_addr", {24'h0, Inst_Addr}, {24'h0, addr_q.pop_front()});
         end
      end
      if (IR_Valid && IR_Ready) begin
         if (ir_q.size() == 0) begin
            chk("unexpected_ir", IR, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = ir_q.pop_front();
            chk("ir",        IR,                e.w);
            chk("ir_pc",     {24'h0, IR_PC},    {24'h0, e.pc});
            chk("rs",        {27'h0, Rs},       {27'h0, e.w[25:21]});
            chk("rt",        {27'h0, Rt},       {27'h0, e.w[20:16]});
            chk("rd",        {27'h0, Rd},       {27'h0, e.w[15:11]});
            chk("alu_op",    {29'h0, ALU_OP},   {29'h0, e.w[2:0]});
            chk("fetch_cnt", {16'h0, Fetch_Cnt}, {16'h0, e.cnt});
         end
      end
   end

   // Advance edges (optionally loading a branch on the first) until IR_Valid.
   task automatic advance(input logic br, input logic [7:0] tgt, output int n);
      Br_Load   = br;
      Br_Target = tgt;
      n = 0;
      do begin
         @(posedge clk_m); #1;
         Br_Load = 1'b0;
         n++;
      end while (!IR_Valid && n < 20);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ir_valid"},  {31'h0, IR_Valid},   32'h0);
      chk({tag, "_rd_en"},     {31'h0, Inst_Rd_En}, 32'h0);
      chk({tag, "_ir"},        IR,                  32'h0);
      chk({tag, "_ir_pc"},     {24'h0, IR_PC},      32'h0);
      chk({tag, "_inst_addr"}, {24'h0, Inst_Addr},  32'h0);
      chk({tag, "_fetch_cnt"}, {16'h0, Fetch_Cnt},  32'h0);
      chk({tag, "_fields"},    {17'h0, Rs, Rt, Rd}, 32'h0);
      chk({tag, "_alu_op"},    {29'h0, ALU_OP},     32'h0);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0843);
      mem[0] = 32'h0043_2802;

      Reset = 1'b0; Run = 1'b0; IR_Ready = 1'b1; Br_Load = 1'b0; Br_Target = 8'h00;
      #12;
      chk_reset_vals("reset");
      Reset = 1'b1;
      @(posedge clk_m); #1;

      // First fetch from reset PC: latency and decoded fields.
      push_fetch(8'h00, 16'd1);
      Run = 1'b1;
      advance(1'b0, 8'h00, n);
      chk("first_latency", n, 3);
      chk("first_ir",     IR, 32'h0043_2802);
      chk("first_rs",     {27'h0, Rs}, 32'd2);
      chk("first_rt",     {27'h0, Rt}, 32'd3);
      chk("first_rd",     {27'h0, Rd}, 32'd5);
      chk("first_alu_op", {29'h0, ALU_OP}, 32'd2);
      chk("first_pc",     {24'h0, Inst_Addr}, 32'h04);
      chk("first_cnt",    {16'h0, Fetch_Cnt}, 32'd1);

      // Branch with misaligned target while consuming: fetch at 0x20.
      push_fetch(8'h20, 16'd2);
      advance(1'b1, 8'h23, n);
      chk("branch_latency", n, 3);

      // Stall five cycles in HOLD.
      IR_Ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_m); #1;
         chk("stall_valid", {31'h0, IR_Valid},   32'h1);
         chk("stall_ir",    IR,                  mem[8]);
         chk("stall_ir_pc", {24'h0, IR_PC},      32'h20);
         chk("stall_rd_en", {31'h0, Inst_Rd_En}, 32'h0);
      end
      chk("stall_pc", {24'h0, Inst_Addr}, 32'h24);
      IR_Ready = 1'b1;
      push_fetch(8'h24, 16'd3);
      advance(1'b0, 8'h00, n);
      chk("release_latency", n, 3);

      // Jump to 0xF8 then run through the PC wrap.
      push_fetch(8'hF8, 16'd4);
      push_fetch(8'hFC, 16'd5);
      push_fetch(8'h00, 16'd6);
      advance(1'b1, 8'hF8, n);
      chk("wrap_gap0", n, 3);
      advance(1'b0, 8'h00, n);
      chk("wrap_gap1", n, 3);
      advance(1'b0, 8'h00, n);
      chk("wrap_gap2", n, 3);
      chk("wrap_pc", {24'h0, Inst_Addr}, 32'h04);

      // Flush during WAIT: read at 0x04 is discarded, refetch at 0x40.
      addr_q.push_back(8'h04);
      push_fetch(8'h40, 16'd7);
      @(posedge clk_m); #1;          // consume -> REQ(0x04)
      @(posedge clk_m); #1;          // -> WAIT
      Br_Load = 1'b1; Br_Target = 8'h40;
      @(posedge clk_m); #1;          // flush -> REQ(0x40)
      Br_Load = 1'b0;
      chk("flush_ir",    IR, mem[0]);
      chk("flush_cnt",   {16'h0, Fetch_Cnt}, 32'd6);
      chk("flush_valid", {31'h0, IR_Valid},  32'h0);
      chk("flush_addr",  {24'h0, Inst_Addr}, 32'h40);
      chk("flush_rd_en", {31'h0, Inst_Rd_En}, 32'h1);
      advance(1'b0, 8'h00, n);
      chk("flush_latency", n, 2);

      // Reset in the middle of a fetch.
      addr_q.push_back(8'h44);
      @(posedge clk_m); #1;          // consume -> REQ(0x44)
      @(posedge clk_m); #1;          // -> WAIT
      #1 Reset = 1'b0;
      #1 chk_reset_vals("midreset");
      @(posedge clk_m); #3;
      push_fetch(8'h00, 16'd1);
      Reset = 1'b1;
      advance(1'b0, 8'h00, n);
      chk("post_reset_latency", n, 3);

      // Consume the last word and go idle.
      Run = 1'b0;
      repeat (4) @(posedge clk_m);
      #1;
      chk("idle_valid", {31'h0, IR_Valid}, 32'h0);
      chk("addr_q_empty", addr_q.size(), 0);
      chk("ir_q_empty", ir_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
